// File: rtl/prog_freq_divide_pkg.sv
// Shared constants and helpers for the programmable clock divider.
`timescale 1ns/1ps
package prog_freq_divide_pkg;

   // Smallest divisor that still yields a real clock (one high, one low phase).
   localparam int unsigned DIV_MIN = 2;

   // Number of posedge cycles p_q stays high in one period: ceil(n/2).
   function automatic logic [31:0] half_ceil(input logic [31:0] n);
      half_ceil = (n >> 1) + {31'd0, n[0]};
   endfunction

endpackage

// File: rtl/fdiv_neg_stage.sv
// Single negedge flop with async active-low clear; the only falling-edge
// element of the divider, kept apart so it is easy to find in timing review.
`timescale 1ns/1ps
module fdiv_neg_stage (
   input  logic i_clk,
   input  logic i_clr_n,
   input  logic i_d,
   output logic o_q
);

   logic r_q;

   // Half-cycle delayed copy of the posedge phase flop.
   always_ff @(negedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_q <= 1'b0;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/prog_freq_divide.sv
// Runtime-programmable clock divider: any N in [2, 2^WIDTH-1], 50% duty for
// both even and odd N, with enable, period tick and boundary-synchronous
// ratio change.
`timescale 1ns/1ps
module prog_freq_divide
   import prog_freq_divide_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DIV_DEFAULT = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] div_val,
   input  logic             div_load,
   output logic             divided_clk,
   output logic             tick,
   output logic             pending,
   output logic             div_err
);

   localparam logic [WIDTH-1:0] LP_DEF  = WIDTH'(DIV_DEFAULT);
   localparam logic [WIDTH-1:0] LP_MIN  = WIDTH'(DIV_MIN);
   localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] LP_ZERO = {WIDTH{1'b0}};

   // State registers
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_cur_div;
   logic [WIDTH-1:0] r_pend_div;
   logic             r_pending;
   logic             r_err;
   logic             r_run;
   logic             r_tick;
   logic             r_p_q;

   // Next-state wires
   logic             w_valid_load;
   logic             w_bad_load;
   logic             w_boundary;
   logic [WIDTH-1:0] w_cnt_n;
   logic [WIDTH-1:0] w_cur_n;
   logic [WIDTH-1:0] w_pend_n;
   logic             w_pending_n;
   logic             w_run_n;
   logic [WIDTH-1:0] w_half_n;
   logic             w_tick_n;
   logic             w_p_n;
   logic             w_n_q;

   // Next-state computation: counter, ratio handover and phase/tick targets.
   always_comb begin
      w_valid_load = div_load && (div_val >= LP_MIN);
      w_bad_load   = div_load && (div_val <  LP_MIN);
      w_boundary   = r_run && (r_cnt == (r_cur_div - LP_ONE));
      w_cnt_n      = r_cnt;
      w_cur_n      = r_cur_div;
      w_pend_n     = r_pend_div;
      w_pending_n  = r_pending;
      w_run_n      = r_run;
      if (!r_run) begin
         // Idle: a valid load (or one left pending at the stop boundary)
         // takes effect at once, and en restarts from cnt=0.
         w_cnt_n     = LP_ZERO;
         w_run_n     = en;
         w_pending_n = 1'b0;
         if (w_valid_load) begin
            w_cur_n  = div_val;
            w_pend_n = div_val;
         end else if (r_pending) begin
            w_cur_n  = r_pend_div;
         end else begin
            w_cur_n  = r_cur_div;
         end
      end else if (w_boundary) begin
         // Period boundary: apply the earlier pending ratio; a load arriving
         // on this very cycle waits for the following boundary.
         w_cnt_n = LP_ZERO;
         w_run_n = en;
         if (r_pending) begin
            w_cur_n = r_pend_div;
         end else begin
            w_cur_n = r_cur_div;
         end
         if (w_valid_load) begin
            w_pend_n    = div_val;
            w_pending_n = 1'b1;
         end else begin
            w_pending_n = 1'b0;
         end
      end else begin
         // Mid-period: keep counting with the old ratio; last load wins.
         w_cnt_n = r_cnt + LP_ONE;
         if (w_valid_load) begin
            w_pend_n    = div_val;
            w_pending_n = 1'b1;
         end else begin
            w_pending_n = r_pending;
         end
      end
      w_half_n = WIDTH'(half_ceil(32'(w_cur_n)));
      w_tick_n = w_run_n && (w_cnt_n == LP_ZERO);
      w_p_n    = w_run_n && (w_cnt_n < w_half_n);
   end

   // Posedge state update with asynchronous active-low clear.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_cnt      <= LP_ZERO;
         r_cur_div  <= LP_DEF;
         r_pend_div <= LP_DEF;
         r_pending  <= 1'b0;
         r_err      <= 1'b0;
         r_run      <= 1'b0;
         r_tick     <= 1'b0;
         r_p_q      <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_n;
         r_cur_div  <= w_cur_n;
         r_pend_div <= w_pend_n;
         r_pending  <= w_pending_n;
         r_run      <= w_run_n;
         r_tick     <= w_tick_n;
         r_p_q      <= w_p_n;
         if (w_bad_load) begin
            r_err <= 1'b1;
         end else begin
            r_err <= r_err;
         end
      end
   end

   fdiv_neg_stage u_neg (
      .i_clk   (clk),
      .i_clr_n (clr),
      .i_d     (r_p_q),
      .o_q     (w_n_q)
   );

   // Odd N trims half a clock off the front of the high phase by ANDing with
   // the negedge copy. cur_div only changes while both phase flops are low.
   assign divided_clk = r_cur_div[0] ? (r_p_q & w_n_q) : r_p_q;
   assign tick        = r_tick;
   assign pending     = r_pending;
   assign div_err     = r_err;

endmodule
